// File: rtl/dds_wave_reader.sv
`default_nettype none
// ============================================================================
// Module   : dds_wave_reader
// Brief    : DDS phase accumulator driving an 8-bit waveform ROM address.
//            Returned ROM data (or a derived square/triangle/midscale value)
//            is amplitude-scaled into a sample stream with a period marker.
//            Config updates are staged in a pending set and applied only at
//            phase-safe points (idle, wrap or sync).
// Revision : 1.0 - initial release
// ============================================================================
module dds_wave_reader #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   sync,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_freq,
  input  logic [ADDR_WIDTH-1:0]  cfg_phase,
  input  logic [1:0]             cfg_wave,
  input  logic [7:0]             cfg_amp,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_q,
  output logic [DATA_WIDTH-1:0]  sample,
  output logic                   sample_valid,
  output logic                   wrap
);

  localparam logic [1:0] WAVE_TABLE  = 2'b00;
  localparam logic [1:0] WAVE_SQUARE = 2'b01;
  localparam logic [1:0] WAVE_TRI    = 2'b10;
  localparam int         PROD_WIDTH  = DATA_WIDTH + 9;

  // Active configuration and accumulator
  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH-1:0] freq;
  logic [ADDR_WIDTH-1:0]  phase;
  logic [1:0]             wave;
  logic [7:0]             amp;

  // Pending configuration slot
  logic                   pend;
  logic [PHASE_WIDTH-1:0] pend_freq;
  logic [ADDR_WIDTH-1:0]  pend_phase;
  logic [1:0]             pend_wave;
  logic [7:0]             pend_amp;

  // Pipeline flags and stage-1 copies
  logic                   p1;
  logic                   carry1;
  logic                   p2;
  logic                   carry2;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [1:0]             wave_d;
  logic [7:0]             amp_d;

  logic [PHASE_WIDTH:0]   sum;
  logic                   step_carry;
  logic                   apply;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  raw;
  logic [DATA_WIDTH-1:0]  tri_up;
  logic [8:0]             amp_p1;
  logic [PROD_WIDTH-1:0]  prod;

  assign sum        = {1'b0, acc} + {1'b0, freq};
  // Only a real enabled step (not a sync) counts as a period wrap.
  assign step_carry = enable & ~sync & sum[PHASE_WIDTH];
  // Pending values are swapped in when the phase is at a safe point.
  assign apply      = pend & (~enable | sync | sum[PHASE_WIDTH]);
  assign accept     = cfg_valid & ~pend;
  assign cfg_ready  = ~pend;

  assign rom_addr   = acc[PHASE_WIDTH-1 -: ADDR_WIDTH] + phase;

  // Accumulator stepping and config accept/apply bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      freq       <= '0;
      phase      <= '0;
      wave       <= WAVE_TABLE;
      amp        <= 8'hFF;
      pend       <= 1'b0;
      pend_freq  <= '0;
      pend_phase <= '0;
      pend_wave  <= WAVE_TABLE;
      pend_amp   <= 8'hFF;
    end else begin
      if (sync) begin
        acc <= '0;
      end else if (enable) begin
        acc <= sum[PHASE_WIDTH-1:0];
      end
      // The carrying step above still used the old freq.
      if (apply) begin
        freq  <= pend_freq;
        phase <= pend_phase;
        wave  <= pend_wave;
        amp   <= pend_amp;
        pend  <= 1'b0;
      end else if (accept) begin
        pend_freq  <= cfg_freq;
        pend_phase <= cfg_phase;
        pend_wave  <= cfg_wave;
        pend_amp   <= cfg_amp;
        pend       <= 1'b1;
      end
    end
  end

  // Step/carry flags launched alongside the accumulator update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1     <= 1'b0;
      carry1 <= 1'b0;
    end else begin
      p1     <= enable;
      carry1 <= step_carry;
    end
  end

  // Stage 1: capture address and shaping controls while the ROM reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2     <= 1'b0;
      carry2 <= 1'b0;
      addr_d <= '0;
      wave_d <= WAVE_TABLE;
      amp_d  <= 8'hFF;
    end else begin
      p2     <= p1;
      carry2 <= carry1;
      addr_d <= rom_addr;
      wave_d <= wave;
      amp_d  <= amp;
    end
  end

  assign tri_up = {addr_d[ADDR_WIDTH-2:0], 1'b0};

  // Select the raw value for the active waveform mode
  always_comb begin
    raw = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    case (wave_d)
      WAVE_TABLE:  raw = rom_q;
      WAVE_SQUARE: raw = {DATA_WIDTH{~addr_d[ADDR_WIDTH-1]}};
      WAVE_TRI:    raw = addr_d[ADDR_WIDTH-1] ? ~tri_up : tri_up;
      default:     raw = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    endcase
  end

  // amp+1 spans 1..256 so full amplitude is an exact pass-through.
  assign amp_p1 = {1'b0, amp_d} + 9'd1;
  assign prod   = PROD_WIDTH'(raw) * PROD_WIDTH'(amp_p1);

  // Stage 2: scaled sample register; sample holds between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      sample_valid <= p2;
      wrap         <= p2 & carry2;
      if (p2) begin
        sample <= prod[DATA_WIDTH+7:8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_wave_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_wave_reader
// Brief    : Scoreboard bench for dds_wave_reader with a saw ROM model,
//            directed scenarios followed by randomized traffic and resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_wave_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        sync = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_freq = '0;
  logic [7:0]  cfg_phase = '0;
  logic [1:0]  cfg_wave = '0;
  logic [7:0]  cfg_amp = '0;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_q = '0;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        wrap;

  dds_wave_reader #(
    .PHASE_WIDTH(32),
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sync        (sync),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_freq    (cfg_freq),
    .cfg_phase   (cfg_phase),
    .cfg_wave    (cfg_wave),
    .cfg_amp     (cfg_amp),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .sample      (sample),
    .sample_valid(sample_valid),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  // Saw-table ROM with a one-cycle registered read
  always @(posedge clk) rom_q <= rom_addr;

  typedef struct {
    int       due;
    int       smp;
    bit       wr;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   ec = 0;
  bit   running = 1'b0;

  // Reference state, expressed as plain numbers
  longint unsigned m_acc, m_freq, p_freq;
  int m_phase, m_wave, m_amp, p_phase, p_wave, p_amp;
  bit m_pend;

  task automatic check(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, expv, ec);
  endtask

  function automatic int ref_sample(input int addr, input int wv, input int am);
    int r;
    case (wv)
      0: r = addr;                                     // saw table contents
      1: r = (addr < 128) ? 255 : 0;
      2: r = (addr < 128) ? 2 * addr : 255 - 2 * (addr - 128);
      default: r = 128;
    endcase
    return (r * (am + 1)) / 256;
  endfunction

  function automatic int ref_addr();
    return int'(((m_acc >> 24) + longint'(m_phase)) % 256);
  endfunction

  task automatic model_reset();
    m_acc = 0; m_freq = 0; m_phase = 0; m_wave = 0; m_amp = 255; m_pend = 0;
    q.delete();
  endtask

  // One clock of stimulus with the reference model advanced on the edge
  task automatic cyc(input bit en, input bit sy, input bit cv, input logic [31:0] f,
                     input logic [7:0] p, input logic [1:0] w, input logic [7:0] a);
    longint unsigned s;
    bit ovf, app, acc_ok;
    enable = en; sync = sy; cfg_valid = cv;
    cfg_freq = f; cfg_phase = p; cfg_wave = w; cfg_amp = a;
    @(posedge clk);
    s      = m_acc + m_freq;
    ovf    = (s >= (64'd1 << 32));
    app    = m_pend && (!en || sy || ovf);
    acc_ok = cv && !m_pend;
    if (sy) m_acc = 0;
    else if (en) m_acc = s % (64'd1 << 32);
    if (app) begin
      m_freq = p_freq; m_phase = p_phase; m_wave = p_wave; m_amp = p_amp; m_pend = 0;
    end else if (acc_ok) begin
      p_freq = longint'(f); p_phase = int'(p); p_wave = int'(w); p_amp = int'(a); m_pend = 1;
    end
    ec++;
    if (en) q.push_back('{due: ec + 2, smp: ref_sample(ref_addr(), m_wave, m_amp),
                          wr: (!sy && ovf)});
    #1;
    check("rom_addr", int'(rom_addr), ref_addr());
    check("cfg_ready", int'(cfg_ready), int'(!m_pend));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_sample_valid", int'(sample_valid), 0);
    check("rst_wrap", int'(wrap), 0);
    enable = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    @(posedge clk);
    ec++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [31:0] f, input logic [7:0] p, input logic [1:0] w,
                      input logic [7:0] a);
    cyc(0, 0, 1, f, p, w, a);
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops the scoreboard whenever a sample is due or presented
  always @(negedge clk) begin
    if (running) begin
      bit exp_v;
      exp_t e;
      exp_v = (q.size() > 0) && (q[0].due == ec);
      check("sample_valid", int'(sample_valid), int'(exp_v));
      if (exp_v) begin
        e = q.pop_front();
        if (sample_valid) begin
          check("sample", int'(sample), e.smp);
          check("wrap", int'(wrap), int'(e.wr));
        end
      end else begin
        check("wrap_idle", int'(wrap), 0);
      end
    end
  end

  initial begin
    #3;
    running = 1'b1;
    do_reset();

    // Saw at full amplitude, full period and wrap
    load(32'h0100_0000, 8'd0, 2'b00, 8'd255);
    run(300);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Half amplitude
    load(32'h0100_0000, 8'd0, 2'b00, 8'd127);
    run(260);
    // Square wave
    load(32'h0100_0000, 8'd0, 2'b01, 8'd255);
    run(300);
    // Constant address with phase offset, then midscale
    load(32'h0, 8'd64, 2'b00, 8'd255);
    run(20);
    load(32'h0, 8'd64, 2'b11, 8'd255);
    run(10);
    // Triangle
    load(32'h0100_0000, 8'd0, 2'b10, 8'd200);
    run(40);
    // Retune while running: held pending until the wrap step
    load(32'h0100_0000, 8'd0, 2'b00, 8'd255);
    cyc(1, 1, 0, 0, 0, 0, 0);
    run(10);
    cyc(1, 0, 1, 32'h0200_0000, 8'd0, 2'b00, 8'd255);
    run(260);
    // Sync with a pending config
    cyc(1, 0, 1, 32'h0100_0000, 8'd5, 2'b10, 8'd99);
    run(20);
    cyc(1, 1, 0, 0, 0, 0, 0);
    run(20);
    // Reset mid-stream with a pending config
    cyc(1, 0, 1, 32'h0300_0000, 8'd7, 2'b01, 8'd50);
    run(3);
    do_reset();
    run(10);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] f;
      case ($urandom_range(0, 3))
        0: f = $urandom;
        1: f = 32'h0100_0000;
        2: f = 32'h0;
        default: f = $urandom >> 6;
      endcase
      if (i % 900 == 899) do_reset();
      cyc(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 6) == 0, f,
          8'($urandom), 2'($urandom), 8'($urandom));
    end

    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("drain", q.size(), 0);
    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
